// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle controller:
// states, opcodes, functs and datapath select codes.
package multi_cycle_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_t;

  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_SRA  = 6'd3;
  localparam logic [5:0] F_JR   = 6'd8;
  localparam logic [5:0] F_JALR = 6'd9;

  localparam logic [1:0] PC_ALU  = 2'd0;
  localparam logic [1:0] PC_JUMP = 2'd1;
  localparam logic [1:0] PC_JR   = 2'd2;
  localparam logic [1:0] PC_OUT  = 2'd3;

  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_REG   = 2'd1;
  localparam logic [1:0] A_SHAMT = 2'd2;

  localparam logic [1:0] B_REG    = 2'd0;
  localparam logic [1:0] B_FOUR   = 2'd1;
  localparam logic [1:0] B_IMM    = 2'd2;
  localparam logic [1:0] B_IMM_SH = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_IMM   = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_ILL  = 2'd1;
  localparam logic [1:0] CAUSE_TMO  = 2'd2;

  typedef struct packed {
    logic r;
    logic shift;
    logic ialu;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic j;
    logic jal;
    logic jr;
    logic jalr;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath bundle: instruction fields
// and memory status in, enables and selects out.
interface multi_cycle_control_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] PCSrc;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       ExtOp;
  logic       LuOp;
  logic       BranchNe;
  logic       exc;
  logic [1:0] exc_cause;
  logic [2:0] state_o;

  modport master (
    output OpCode, Funct, Zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead,
    input  MemWrite, IRWrite, RegWrite,
    input  PCSrc, RegDst, MemtoReg,
    input  ALUSrcA, ALUSrcB, ALUOp,
    input  ExtOp, LuOp, BranchNe,
    input  exc, exc_cause, state_o
  );

  modport slave (
    input  OpCode, Funct, Zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead,
    output MemWrite, IRWrite, RegWrite,
    output PCSrc, RegDst, MemtoReg,
    output ALUSrcA, ALUSrcB, ALUOp,
    output ExtOp, LuOp, BranchNe,
    output exc, exc_cause, state_o
  );
endinterface

// File: rtl/instr_class_decode.sv
// Combinational instruction-class decode from
// OpCode/Funct; bne legality follows EN_BNE.
module instr_class_decode
  import multi_cycle_pkg::*;
#(
  parameter bit EN_BNE = 1'b1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  logic r_op;

  // Classify; jr/jalr are R-format but act as jumps.
  always_comb begin
    cls  = '0;
    r_op = (opcode == OP_R);
    cls.jr    = r_op && (funct == F_JR);
    cls.jalr  = r_op && (funct == F_JALR);
    cls.r     = r_op && !cls.jr && !cls.jalr;
    cls.shift = r_op && (funct == F_SLL ||
                funct == F_SRL || funct == F_SRA);
    cls.ialu  = opcode inside {OP_ADDI, OP_ADDIU,
                OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI};
    cls.load  = (opcode == OP_LW);
    cls.store = (opcode == OP_SW);
    cls.branch = (opcode == OP_BEQ) ||
                 (EN_BNE && opcode == OP_BNE);
    cls.j     = (opcode == OP_J);
    cls.jal   = (opcode == OP_JAL);
    cls.jump  = cls.j | cls.jal | cls.jr | cls.jalr;
    cls.illegal = !(r_op | cls.ialu | cls.load |
                    cls.store | cls.branch |
                    cls.j | cls.jal);
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM with memory
// wait timeout and illegal-opcode exceptions.
module multi_cycle_control
  import multi_cycle_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8,
  parameter bit          EN_BNE   = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  multi_cycle_control_if.slave bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic [1:0] cause;
  logic [1:0] cause_next;
  logic       timeout;
  iclass_t    cls;

  instr_class_decode #(.EN_BNE(EN_BNE)) u_dec (
    .opcode(bus.OpCode),
    .funct (bus.Funct),
    .cls   (cls)
  );

  // State, wait counter and held exception cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IF;
      wait_cnt <= '0;
      cause    <= CAUSE_NONE;
    end else begin
      state <= state_next;
      cause <= cause_next;
      if (state_next == state &&
          (state == S_IF || state == S_MEM))
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
    end
  end

  // Next state and datapath controls.
  always_comb begin
    state_next      = state;
    cause_next      = cause;
    timeout         = !bus.mem_ready &&
                      (wait_cnt == WAIT_LAST);
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.PCSrc       = PC_ALU;
    bus.RegDst      = DST_RT;
    bus.MemtoReg    = M2R_ALU;
    bus.ALUSrcA     = A_PC;
    bus.ALUSrcB     = B_REG;
    bus.ALUOp       = ALU_ADD;
    bus.BranchNe    = 1'b0;
    bus.exc         = 1'b0;
    bus.ExtOp       = (bus.OpCode != OP_ANDI);
    bus.LuOp        = (bus.OpCode == OP_LUI);
    bus.exc_cause   = cause;
    bus.state_o     = state;

    unique case (state)
      S_IF: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = B_FOUR;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready) begin
          state_next = S_ID;
        end else if (timeout) begin
          state_next = S_EXC;
          cause_next = CAUSE_TMO;
        end
      end
      S_ID: begin
        bus.ALUSrcB = B_IMM_SH;
        state_next  = S_EX;
        unique case (1'b1)
          cls.illegal: begin
            state_next = S_EXC;
            cause_next = CAUSE_ILL;
          end
          cls.j, cls.jal: begin
            bus.PCWrite = 1'b1;
            bus.PCSrc   = PC_JUMP;
            state_next  = S_IF;
            if (cls.jal) begin
              bus.RegWrite = 1'b1;
              bus.RegDst   = DST_RA;
              bus.MemtoReg = M2R_PC;
            end
          end
          cls.jr, cls.jalr: begin
            bus.PCWrite = 1'b1;
            bus.PCSrc   = PC_JR;
            state_next  = S_IF;
            if (cls.jalr) begin
              bus.RegWrite = 1'b1;
              bus.RegDst   = DST_RD;
              bus.MemtoReg = M2R_PC;
            end
          end
          default: ;
        endcase
      end
      S_EX: begin
        state_next = S_WB;
        unique case (1'b1)
          cls.branch: begin
            bus.ALUOp       = ALU_SUB;
            bus.PCWriteCond = 1'b1;
            bus.PCSrc       = PC_OUT;
            bus.BranchNe    = (bus.OpCode == OP_BNE);
            state_next      = S_IF;
          end
          cls.load, cls.store: begin
            bus.ALUSrcA = A_REG;
            bus.ALUSrcB = B_IMM;
            state_next  = S_MEM;
          end
          cls.ialu: begin
            bus.ALUSrcA = A_REG;
            bus.ALUSrcB = B_IMM;
            bus.ALUOp   = ALU_IMM;
          end
          cls.shift: begin
            bus.ALUSrcA = A_SHAMT;
            bus.ALUOp   = ALU_FUNCT;
          end
          cls.r && !cls.shift: begin
            bus.ALUSrcA = A_REG;
            bus.ALUOp   = ALU_FUNCT;
          end
          default: state_next = S_IF;
        endcase
      end
      S_MEM: begin
        bus.IorD     = 1'b1;
        bus.MemRead  = cls.load;
        bus.MemWrite = cls.store && !timeout;
        if (bus.mem_ready) begin
          state_next = cls.load ? S_WB : S_IF;
        end else if (timeout) begin
          state_next = S_EXC;
          cause_next = CAUSE_TMO;
        end
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        state_next   = S_IF;
        if (cls.load)
          bus.MemtoReg = M2R_MEM;
        else if (cls.r)
          bus.RegDst = DST_RD;
      end
      S_EXC: begin
        bus.exc     = 1'b1;
        bus.PCWrite = 1'b1;
        bus.PCSrc   = PC_OUT;
        state_next  = S_IF;
      end
      default: state_next = S_IF;
    endcase

    if (reset) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.exc         = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: default
// instance plus an EN_BNE=0 instance.
module tb_multi_cycle_control;

  logic clk = 1'b0;
  logic reset;
  logic reset0;
  int   errors = 0;
  int   checks = 0;

  multi_cycle_control_if bus ();
  multi_cycle_control_if bus0 ();

  multi_cycle_control dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  multi_cycle_control #(.EN_BNE(1'b0)) dut_nb (
    .clk  (clk),
    .reset(reset0),
    .bus  (bus0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] enables();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD,
            bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.RegWrite, bus.exc};
  endfunction

  initial begin
    int  n;
    logic ir_seen;
    reset          = 1'b1;
    reset0         = 1'b1;
    bus.OpCode     = 6'd0;
    bus.Funct      = 6'd32;
    bus.Zero       = 1'b0;
    bus.mem_ready  = 1'b1;
    bus0.OpCode    = 6'd5;
    bus0.Funct     = 6'd0;
    bus0.Zero      = 1'b0;
    bus0.mem_ready = 1'b1;
    #2;
    check("rst_enables", enables(), 0);
    tick();
    check("rst_state", bus.state_o, 0);
    check("rst_cause", bus.exc_cause, 0);
    check("rst_irwrite", bus.IRWrite, 0);

    // bne illegal when EN_BNE=0
    reset0 = 1'b0;
    #1;
    check("nb_if", bus0.state_o, 0);
    check("nb_if_irw", bus0.IRWrite, 1);
    tick();
    check("nb_id", bus0.state_o, 1);
    tick();
    check("nb_exc_state", bus0.state_o, 5);
    check("nb_exc", bus0.exc, 1);
    check("nb_cause", bus0.exc_cause, 1);
    tick();
    check("nb_back_if", bus0.state_o, 0);
    check("rst_hold_memread", bus.MemRead, 0);

    reset = 1'b0;
    #1;
    check("if_memread", bus.MemRead, 1);
    check("if_irwrite", bus.IRWrite, 1);
    check("if_pcwrite", bus.PCWrite, 1);
    check("if_srcb", bus.ALUSrcB, 1);

    // add: IF ID EX WB
    check("add_c1_rw", bus.RegWrite, 0);
    tick();
    check("add_c2_state", bus.state_o, 1);
    check("add_c2_srcb", bus.ALUSrcB, 3);
    check("add_c2_rw", bus.RegWrite, 0);
    tick();
    check("add_c3_state", bus.state_o, 2);
    check("add_c3_srca", bus.ALUSrcA, 1);
    check("add_c3_aluop", bus.ALUOp, 2);
    check("add_c3_rw", bus.RegWrite, 0);
    tick();
    check("add_c4_state", bus.state_o, 4);
    check("add_c4_rw", bus.RegWrite, 1);
    check("add_c4_dst", bus.RegDst, 1);
    check("add_c4_m2r", bus.MemtoReg, 0);
    tick();
    check("add_done", bus.state_o, 0);

    // lw with ready delayed 3 cycles in MEM
    bus.OpCode = 6'd35;
    tick();
    check("lw_id", bus.state_o, 1);
    tick();
    check("lw_ex_srcb", bus.ALUSrcB, 2);
    check("lw_ex_aluop", bus.ALUOp, 0);
    bus.mem_ready = 1'b0;
    tick();
    check("lw_mem_iord", bus.IorD, 1);
    check("lw_mem_rd", bus.MemRead, 1);
    check("lw_mem_wr", bus.MemWrite, 0);
    tick();
    check("lw_mem2", bus.state_o, 3);
    tick();
    check("lw_mem3", bus.state_o, 3);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    check("lw_mem4", bus.state_o, 3);
    tick();
    check("lw_wb_state", bus.state_o, 4);
    check("lw_wb_m2r", bus.MemtoReg, 1);
    check("lw_wb_dst", bus.RegDst, 0);
    check("lw_wb_rw", bus.RegWrite, 1);
    tick();
    check("lw_done", bus.state_o, 0);

    // fetch timeout with ready stuck low
    bus.mem_ready = 1'b0;
    bus.OpCode    = 6'd0;
    #1;
    n       = 0;
    ir_seen = 1'b0;
    while (!bus.exc && n < 20) begin
      if (bus.IRWrite) ir_seen = 1'b1;
      tick();
      n++;
    end
    check("tmo_if_cycles", n, 8);
    check("tmo_irwrite", ir_seen, 0);
    check("tmo_exc", bus.exc, 1);
    check("tmo_cause", bus.exc_cause, 2);
    check("tmo_pcsrc", bus.PCSrc, 3);
    check("tmo_pcw", bus.PCWrite, 1);
    tick();
    check("tmo_exc_once", bus.exc, 0);
    check("tmo_back_if", bus.state_o, 0);
    check("tmo_cause_hold", bus.exc_cause, 2);

    // ready wins on the last wait cycle
    bus.OpCode = 6'd5;
    for (int i = 0; i < 7; i++) tick();
    bus.mem_ready = 1'b1;
    #1;
    check("rdy_win_exc", bus.exc, 0);
    check("rdy_win_irw", bus.IRWrite, 1);
    tick();
    check("rdy_win_id", bus.state_o, 1);

    // bne, Zero=0
    tick();
    check("bne_ex", bus.state_o, 2);
    check("bne_pwc", bus.PCWriteCond, 1);
    check("bne_bne", bus.BranchNe, 1);
    check("bne_pcsrc", bus.PCSrc, 3);
    check("bne_aluop", bus.ALUOp, 1);
    tick();
    check("bne_done", bus.state_o, 0);

    // reset during sw MEM
    bus.OpCode = 6'd43;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    check("sw_mem_wr", bus.MemWrite, 1);
    check("sw_mem_iord", bus.IorD, 1);
    reset = 1'b1;
    #1;
    check("sw_rst_wr", bus.MemWrite, 0);
    tick();
    check("sw_rst_if", bus.state_o, 0);
    check("sw_rst_cause", bus.exc_cause, 0);
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    #1;

    // jal: 2 cycles
    bus.OpCode = 6'd3;
    tick();
    check("jal_id", bus.state_o, 1);
    check("jal_pcw", bus.PCWrite, 1);
    check("jal_pcsrc", bus.PCSrc, 1);
    check("jal_rw", bus.RegWrite, 1);
    check("jal_dst", bus.RegDst, 2);
    check("jal_m2r", bus.MemtoReg, 2);
    tick();
    check("jal_done", bus.state_o, 0);

    // jr
    bus.OpCode = 6'd0;
    bus.Funct  = 6'd8;
    tick();
    check("jr_pcw", bus.PCWrite, 1);
    check("jr_pcsrc", bus.PCSrc, 2);
    check("jr_rw", bus.RegWrite, 0);
    tick();
    check("jr_done", bus.state_o, 0);

    // illegal opcode
    bus.OpCode = 6'd63;
    tick();
    tick();
    check("ill_state", bus.state_o, 5);
    check("ill_exc", bus.exc, 1);
    check("ill_cause", bus.exc_cause, 1);
    tick();
    check("ill_done", bus.state_o, 0);

    // immediate controls
    bus.OpCode = 6'd12;
    #1;
    check("andi_ext", bus.ExtOp, 0);
    check("andi_lu", bus.LuOp, 0);
    bus.OpCode = 6'd15;
    #1;
    check("lui_ext", bus.ExtOp, 1);
    check("lui_lu", bus.LuOp, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter MAX_WAIT, default 8: max cycles to wait for mem_ready before a timeout exception (1..255).
REQ-002 Parameter EN_BNE, default 1: when 1, OpCode 5 (bne) is legal; when 0, OpCode 5 is illegal.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 OpCode  input  6  IR[31:26]; valid from state ID onward.
REQ-006 Funct  input  6  IR[5:0]; valid from state ID onward.
REQ-007 Zero  input  1  ALU zero flag, sampled in EX.
REQ-008 mem_ready  input  1  memory completes the current access this cycle.
REQ-009 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables.
REQ-010 PCSrc, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp  output  2 each  datapath selects.
REQ-011 ExtOp, LuOp, BranchNe  output  1 each  immediate and branch-sense controls.
REQ-012 exc, exc_cause  output  1, 2  exception pulse; cause 1 = illegal op, 2 = memory timeout.
REQ-013 state_o  output  3  current state, for debug.

Function
REQ-014 The FSM SHALL have states IF, ID, EX, MEM, WB and EXC; every output is a function of the state, OpCode, Funct, Zero and mem_ready only.
REQ-015 IF SHALL assert MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1 (constant 4), ALUOp=0 (add) and PCSrc=0, with IRWrite=PCWrite=mem_ready; on mem_ready go to ID, otherwise stay in IF.
REQ-016 ID SHALL set ALUSrcA=0, ALUSrcB=3 (imm<<2) and ALUOp=0 to form the branch target, then transition as follows.
  - j: PCWrite=1, PCSrc=1 (jump target) -> IF.
  - jal: as j, plus RegWrite=1, RegDst=2, MemtoReg=2 -> IF.
  - jr (Funct 8): PCWrite=1, PCSrc=2 -> IF.
  - jalr (Funct 9): as jr, plus RegWrite=1, RegDst=1, MemtoReg=2 -> IF.
  - illegal opcode -> EXC.
  - all others -> EX.
REQ-017 Legal set: R-type; 35, 43, 15, 8, 9, 12, 10, 11, 4, 2, 3; and 5 when EN_BNE=1.
REQ-018 EX SHALL operate per class, then transition as follows.
  - Shifts (Funct 0/2/3): ALUSrcA=2 (shamt).
  - R-type: ALUSrcA=1, ALUSrcB=0, ALUOp=2.
  - I-type ALU and lui: ALUSrcA=1, ALUSrcB=2, ALUOp=3.
  - lw/sw: ALUSrcA=1, ALUSrcB=2, ALUOp=0.
  - beq/bne: ALUOp=1, PCWriteCond=1, PCSrc=3 (ALUOut), BranchNe=(OpCode==5) -> IF.
  - lw/sw -> MEM; all others -> WB.
REQ-019 ExtOp SHALL be 0 only for OpCode 12; LuOp SHALL be 1 only for OpCode 15.
REQ-020 MEM SHALL assert IorD=1 with MemRead=1 (lw) or MemWrite=1 (sw); on mem_ready, sw -> IF and lw -> WB.
REQ-021 WB SHALL assert RegWrite=1 for one cycle and then go to IF.
  - lw: MemtoReg=1, RegDst=0.
  - R-type: MemtoReg=0, RegDst=1.
  - I-type: MemtoReg=0, RegDst=0.
REQ-022 EXC SHALL assert exc=1 and PCWrite=1 with PCSrc=3, hold exc_cause stable, and go to IF after exactly one cycle.
REQ-023 A wait counter SHALL clear on entry to IF or MEM and increment each cycle while mem_ready=0; reaching MAX_WAIT SHALL force EXC with exc_cause=2 and no write enable asserted in that cycle.
REQ-024 If mem_ready=1 in the same cycle the counter reaches MAX_WAIT, the access SHALL complete normally (ready wins).
REQ-025 Latency with mem_ready tied to 1:
  - j/jal/jr/jalr: 2 cycles.
  - beq/bne: 3 cycles.
  - sw, R-type, I-type: 4 cycles.
  - lw: 5 cycles.
REQ-026 All enables not listed for a state SHALL be 0; selects not listed SHALL be 0.

Reset
REQ-027 While reset=1, all enables and exc SHALL be 0; on the next edge, state SHALL be IF, the counter 0 and exc_cause 0.
REQ-028 Reset asserted mid-instruction (including in MEM with MemWrite high) SHALL abort it; no write enable is asserted in the reset cycle.

Structure
REQ-029 A shared package multi_cycle_pkg SHALL hold the state encoding, opcode and funct constants, and the PCSrc, ALUSrc and ALUOp encodings.
REQ-030 Instruction-class decode (R, shift, I-ALU, load, store, branch, jump, illegal) SHALL be a combinational sub-module, instr_class_decode, instantiated once.

Verification
REQ-031 add (OpCode 0, Funct 32), mem_ready=1 -> states IF, ID, EX, WB; RegWrite=1 with RegDst=1 only in cycle 4.
REQ-032 lw with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles, then WB with MemtoReg=1; total 8 cycles.
REQ-033 bne with Zero=0 and EN_BNE=1 -> EX asserts PCWriteCond=1, BranchNe=1; with EN_BNE=0 -> EXC, exc_cause=1.
REQ-034 mem_ready held 0 in IF, MAX_WAIT=8 -> exc=1 for 1 cycle with exc_cause=2; IRWrite never asserted.
REQ-035 reset pulse during sw MEM -> MemWrite=0 in the reset cycle; state_o=IF on the next cycle.
REQ-036 jal -> 2 cycles; ID asserts PCWrite=1, PCSrc=1, RegWrite=1, RegDst=2, MemtoReg=2.
